// File: rtl/distortion_pkg.sv
// Shared types and helpers for the distortion datapath and its settings controller.
package distortion_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GAIN   = 2'd1,
    MODE_RECT   = 2'd2,
    MODE_CLIP   = 2'd3
  } mode_t;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  localparam logic signed [32:0] P33_MAX = 33'(SAMPLE_MAX);
  localparam logic signed [32:0] P33_MIN = 33'(SAMPLE_MIN);

  function automatic logic in_range16(input logic signed [32:0] p);
    return (p <= P33_MAX) && (p >= P33_MIN);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [32:0] p);
    if (p > P33_MAX) begin
      return 16'sh7fff;
    end else if (p < P33_MIN) begin
      return 16'sh8000;
    end else begin
      return p[15:0];
    end
  endfunction

endpackage

// File: rtl/clip_indicator.sv
// Saturating clip counter and stretched clip LED driven by delivered clipped samples.
module clip_indicator
  import distortion_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2_500_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clip_event,
  input  logic        clip_clear,
  output logic [15:0] clip_count,
  output logic        clip_led
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  logic [15:0]      count_q, count_d;
  logic [HoldW-1:0] hold_q, hold_d;

  always_comb begin
    count_d = count_q;
    if (clip_clear) begin
      count_d = '0;
    end else if (clip_event && (count_q != 16'hffff)) begin
      count_d = count_q + 16'd1;
    end

    hold_d = hold_q;
    if (clip_event) begin
      hold_d = HoldW'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  assign clip_count = count_q;
  assign clip_led   = (hold_q != '0);

endmodule

// File: rtl/distortion_core.sv
// Streaming distortion datapath: capture, compute and saturate stages plus an output
// register, all advancing together under a single global stall.
module distortion_core
  import distortion_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2_500_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [15:0] gain,
  input  logic signed [31:0] threshold,
  input  logic        [1:0]  mode,
  input  logic signed [15:0] in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] out_sample,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clip_clear,
  output logic        [15:0] clip_count,
  output logic               clip_led
);

  logic adv;

  logic               s1_valid_q;
  logic signed [15:0] s1_sample_q;
  logic signed [15:0] s1_gain_q;
  logic signed [31:0] s1_thr_q;
  mode_t              s1_mode_q;

  logic               s2_valid_q;
  logic signed [32:0] s2_p_q;
  logic               s2_clip_q;

  logic               s3_valid_q;
  logic signed [15:0] s3_sample_q;
  logic               s3_clip_q;

  logic               out_valid_q;
  logic signed [15:0] out_sample_q;
  logic               out_clip_q;

  logic signed [32:0] s33, t33, p_d;
  logic signed [31:0] prod;
  logic               clip_d;
  logic               clip_event;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    s33  = {{17{s1_sample_q[15]}}, s1_sample_q};
    prod = 32'(s1_sample_q) * 32'(s1_gain_q);
    // Threshold clamped into 0..32767 before use as a symmetric limit.
    if (s1_thr_q[31]) begin
      t33 = '0;
    end else if (s1_thr_q > 32'sd32767) begin
      t33 = P33_MAX;
    end else begin
      t33 = 33'(s1_thr_q);
    end

    p_d    = s33;
    clip_d = 1'b0;
    unique case (s1_mode_q)
      MODE_BYPASS: p_d = s33;
      MODE_GAIN:   p_d = 33'(prod);
      MODE_RECT:   p_d = s1_sample_q[15] ? -s33 : s33;
      MODE_CLIP: begin
        if (s33 > t33) begin
          p_d    = t33;
          clip_d = 1'b1;
        end else if (s33 < -t33) begin
          p_d    = -t33;
          clip_d = 1'b1;
        end
      end
      default: p_d = s33;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q   <= 1'b0;
      s1_sample_q  <= '0;
      s1_gain_q    <= '0;
      s1_thr_q     <= '0;
      s1_mode_q    <= MODE_BYPASS;
      s2_valid_q   <= 1'b0;
      s2_p_q       <= '0;
      s2_clip_q    <= 1'b0;
      s3_valid_q   <= 1'b0;
      s3_sample_q  <= '0;
      s3_clip_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_clip_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      // Settings travel with the sample so later changes never touch it.
      if (in_valid) begin
        s1_sample_q <= in_sample;
        s1_gain_q   <= gain;
        s1_thr_q    <= threshold;
        s1_mode_q   <= mode_t'(mode);
      end
      if (s1_valid_q) begin
        s2_p_q    <= p_d;
        s2_clip_q <= clip_d;
      end
      if (s2_valid_q) begin
        s3_sample_q <= sat16(s2_p_q);
        s3_clip_q   <= s2_clip_q || !in_range16(s2_p_q);
      end
      if (s3_valid_q) begin
        out_sample_q <= s3_sample_q;
        out_clip_q   <= s3_clip_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign clip_event = out_valid_q && out_ready && out_clip_q;

  clip_indicator #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_clip_indicator (
    .CLK       (CLK),
    .RST       (RST),
    .clip_event(clip_event),
    .clip_clear(clip_clear),
    .clip_count(clip_count),
    .clip_led  (clip_led)
  );

endmodule

// File: doc/distortion_core.md
# distortion_core

Streaming audio distortion datapath that consumes the `gain`, `threshold` and `mode` settings produced by the distortion settings controller and applies them to 16-bit signed PCM samples. It sits between the audio codec receive path and the transmit path. It uses a 3-stage valid/ready pipeline and latches the settings per sample. It also drives a clip-activity LED and a saturating clip counter for the front panel.

## Interface
- `HOLD_CYCLES`, default 2_500_000: clip LED hold time in `CLK` cycles (50 ms at 50 MHz); must be ≥1.
- `CLK`  in  1  system clock, all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `gain`  in  16 signed  multiplier for mode 1, from the settings controller.
- `threshold`  in  32 signed  clip level for mode 3, from the settings controller.
- `mode`  in  2  0 bypass, 1 gain, 2 rectify, 3 hard clip.
- `in_sample`  in  16 signed  input PCM sample.
- `in_valid`  in  1  `in_sample` is valid.
- `in_ready`  out  1  the block accepts the sample this cycle.
- `out_sample`  out  16 signed  processed sample.
- `out_valid`  out  1  `out_sample` is valid.
- `out_ready`  in  1  the downstream stage accepts the sample.
- `clip_clear`  in  1  synchronous clear of `clip_count`.
- `clip_count`  out  16  number of clipped samples, saturating at 65535.
- `clip_led`  out  1  stretched clip indicator.

## Operation
- **S1 capture:** on accept (`in_valid && in_ready`), register the sample. Latch `gain`, `threshold` and `mode` together with it. Settings changes never affect a sample already in flight.
- **S2 compute:** produce a 33-bit signed intermediate `p` and a `clip` flag, by mode:
  - Mode 0: `p = s`, `clip = 0`.
  - Mode 1: `p = s*gain`, computed as a full 32-bit signed product.
  - Mode 2: `p = |s|`. Input -32768 gives 32768.
  - Mode 3:
    - `t = threshold` clamped to the range 0..32767.
    - `p = s` clamped to the range -t..t.
    - `clip = 1` when `|s| > t`.
- **S3 saturate:** `out_sample = sat16(p)`, which clamps to -32768..32767. `clip` is additionally set whenever saturation changed the value. For example, in mode 2 an input of -32768 outputs 32767 with `clip = 1`.
- **Clip counter:** increments by 1 for each *delivered* sample with `clip = 1`, i.e. when `out_valid && out_ready` and S3 `clip` is set.
  - Saturates at 65535.
  - `clip_clear` sets it to 0. Clear wins over a same-cycle increment.
- **Clip LED:** each delivered clipped sample reloads the hold counter with `HOLD_CYCLES`.
  - `clip_led = (hold counter != 0)`.
  - The hold counter decrements by 1 per cycle down to 0.
  - A reload wins over a same-cycle decrement.

## Timing
- Global advance: `adv = !out_valid || out_ready`. All stages shift when `adv` is 1 and hold when it is 0.
- `in_ready = adv`. It is combinational from `out_valid` and `out_ready`.
- Each stage has its own valid bit. Bubbles propagate and are not compressed.
- Latency: a sample accepted on edge N appears with `out_valid = 1` after edge N+3 when there is no back-pressure. Throughput is 1 sample per cycle.
- `out_sample` and `out_valid` hold stable while `out_valid && !out_ready`.
- Reset values:
  - All stage valids 0, so `out_valid = 0`.
  - `out_sample = 0`, `clip_count = 0`, hold counter 0, `clip_led = 0`.
  - Latched settings are 0 (bypass).
- Reset mid-stream discards every in-flight sample. No partial output is produced.
- The multiply is a single-cycle signed 16×16 product in S2. It must not be split across stages.
- A `clip_led` rising edge occurs on the cycle after the clipped sample is delivered.

## Structure
- Package `distortion_pkg`:
  - `mode_t` enum: `MODE_BYPASS = 0`, `MODE_GAIN = 1`, `MODE_RECT = 2`, `MODE_CLIP = 3`.
  - `SAMPLE_MAX = 32767`, `SAMPLE_MIN = -32768`.
  - `sat16` function.
  - This package is shared with the settings controller.
- Sub-module `clip_indicator` holds the saturating counter, the hold counter and the LED. Its inputs are `CLK`, `RST`, `clip_event`, `clip_clear` and `HOLD_CYCLES`.
- Top level: pipeline registers plus the mode-select datapath.

## Test plan
- **Bypass latency.** Mode 0, `out_ready = 1`, stream 100, -200, 300 on consecutive cycles. Expect outputs 100, -200, 300 exactly 3 cycles after each accept. `clip_count` stays 0.
- **Gain saturation.** Mode 1, `gain = 50`, inputs 600 and -700. Expect 30000 and -32768. `clip_count = 1` and `clip_led` goes high; with `HOLD_CYCLES = 4` it falls 4 cycles later.
- **Rectify and clip.** Mode 2, inputs -32768 and -5. Expect 32767 (clip) and 5. Then mode 3 with `threshold = 1000`, inputs 1500, -1500, 999. Expect 1000, -1000, 999, with `clip_count` increasing by 2. Also check that `threshold = 40000` passes 32767 unchanged.
- **Back-pressure.** Hold `out_ready = 0` for 5 cycles with `in_valid = 1`. `in_ready` drops once `out_valid` is 1, and `out_sample` stays stable. On release, no samples are lost or duplicated and order is preserved.
- **Settings latched per sample.** Toggle `gain` from 2 to 3 on the cycle after an accept. The in-flight sample 1000 must still output 2000.
- **Reset and boundaries.**
  - Assert `RST` with 3 samples in flight: `out_valid` drops immediately and no outputs follow.
  - Preload `clip_count` to 65535 with a further clip: it stays at 65535.
  - Same-cycle `clip_clear` and clip: count ends at 0.
